// File: rtl/imem_read_arbiter.sv
// ---------------------------------------------------------------------------
// imem_read_arbiter
//
// Shares the single combinational read port of the instruction memory between
// the fetch stage (Fetch) and the debug/trace reader (Dbg). The granted,
// word-aligned address is registered onto MemAddress. The word that comes back
// on MemInstruction is captured one cycle later and returned to the winner with
// a one-cycle Ack pulse. Fetch has fixed priority. A wait counter force-grants
// Dbg once it has been denied for MAX_WAIT consecutive edges.
//
// Optional build macro: IMEM_ARB_STATS_EN adds grant counters and a peak-wait
// monitor (FetchGrantCount, DbgGrantCount, MaxDbgWait).
//
// Ports:
//   Clk             in   system clock, rising edge
//   Reset           in   asynchronous active-low reset
//   FetchReq/Addr   in   fetch request and byte address (held until FetchAck)
//   FetchAck/Data   out  one-cycle ack pulse and registered word for fetch
//   DbgReq/Addr     in   debug request and byte address (held until DbgAck)
//   DbgAck/Data     out  one-cycle ack pulse and registered word for debug
//   MemAddress      out  instruction memory address
//   MemInstruction  in   instruction memory read data
//   Busy            out  high while a read is in flight
//   FetchGrantCount out  (stats build) fetch acks since reset, wraps
//   DbgGrantCount   out  (stats build) debug acks since reset, wraps
//   MaxDbgWait      out  (stats build) largest wait count seen since reset
// ---------------------------------------------------------------------------
module imem_read_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_WAIT   = 8
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  FetchReq,
    input  logic [ADDR_WIDTH-1:0] FetchAddr,
    output logic                  FetchAck,
    output logic [DATA_WIDTH-1:0] FetchData,
    input  logic                  DbgReq,
    input  logic [ADDR_WIDTH-1:0] DbgAddr,
    output logic                  DbgAck,
    output logic [DATA_WIDTH-1:0] DbgData,
    output logic [ADDR_WIDTH-1:0] MemAddress,
    input  logic [DATA_WIDTH-1:0] MemInstruction,
    output logic                  Busy
`ifdef IMEM_ARB_STATS_EN
    ,
    output logic [15:0]           FetchGrantCount,
    output logic [15:0]           DbgGrantCount,
    output logic [7:0]            MaxDbgWait
`endif
);

    typedef enum logic [0:0] {StIdle, StIssue} state_e;

    localparam logic       OwnFetch = 1'b0;
    localparam logic       OwnDbg   = 1'b1;
    localparam logic [7:0] MaxWaitC = 8'(MAX_WAIT);

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  fetch_ack_q, fetch_ack_d;
    logic                  dbg_ack_q, dbg_ack_d;
    logic [DATA_WIDTH-1:0] fetch_data_q, fetch_data_d;
    logic [DATA_WIDTH-1:0] dbg_data_q, dbg_data_d;
    logic [7:0]            wait_cnt_q, wait_cnt_d;

    logic ack_edge;
    logic fetch_elig, dbg_elig;
    logic grant_fetch, grant_dbg;

`ifdef IMEM_ARB_STATS_EN
    logic [15:0] fetch_cnt_q, fetch_cnt_d;
    logic [15:0] dbg_cnt_q, dbg_cnt_d;
    logic [7:0]  max_wait_q, max_wait_d;
`endif

    always_comb begin
        state_d      = StIdle;
        owner_d      = owner_q;
        mem_addr_d   = mem_addr_q;
        fetch_ack_d  = 1'b0;
        dbg_ack_d    = 1'b0;
        fetch_data_d = fetch_data_q;
        dbg_data_d   = dbg_data_q;
        wait_cnt_d   = wait_cnt_q;

        // The memory has had a full cycle to settle: return its word to the owner.
        ack_edge = (state_q == StIssue);
        if (ack_edge) begin
            if (owner_q == OwnDbg) begin
                dbg_ack_d  = 1'b1;
                dbg_data_d = MemInstruction;
            end else begin
                fetch_ack_d  = 1'b1;
                fetch_data_d = MemInstruction;
            end
        end

        // The owner being acked on this edge still shows its old request; ignore it.
        fetch_elig = FetchReq && !(ack_edge && (owner_q == OwnFetch));
        dbg_elig   = DbgReq   && !(ack_edge && (owner_q == OwnDbg));

        grant_dbg   = dbg_elig && ((wait_cnt_q >= MaxWaitC) || !fetch_elig);
        grant_fetch = fetch_elig && !grant_dbg;

        if (grant_dbg) begin
            owner_d    = OwnDbg;
            mem_addr_d = {DbgAddr[ADDR_WIDTH-1:2], 2'b00};
            state_d    = StIssue;
        end else if (grant_fetch) begin
            owner_d    = OwnFetch;
            mem_addr_d = {FetchAddr[ADDR_WIDTH-1:2], 2'b00};
            state_d    = StIssue;
        end

        if (!DbgReq || grant_dbg) begin
            wait_cnt_d = 8'd0;
        end else if (wait_cnt_q != 8'hFF) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

`ifdef IMEM_ARB_STATS_EN
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        dbg_cnt_d   = dbg_cnt_q;
        max_wait_d  = max_wait_q;
        if (fetch_ack_d) begin
            fetch_cnt_d = fetch_cnt_q + 16'd1;
        end
        if (dbg_ack_d) begin
            dbg_cnt_d = dbg_cnt_q + 16'd1;
        end
        if (wait_cnt_d > max_wait_q) begin
            max_wait_d = wait_cnt_d;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            fetch_cnt_q <= 16'd0;
            dbg_cnt_q   <= 16'd0;
            max_wait_q  <= 8'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            dbg_cnt_q   <= dbg_cnt_d;
            max_wait_q  <= max_wait_d;
        end
    end

    assign FetchGrantCount = fetch_cnt_q;
    assign DbgGrantCount   = dbg_cnt_q;
    assign MaxDbgWait      = max_wait_q;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= StIdle;
            owner_q      <= OwnFetch;
            mem_addr_q   <= '0;
            fetch_ack_q  <= 1'b0;
            dbg_ack_q    <= 1'b0;
            fetch_data_q <= '0;
            dbg_data_q   <= '0;
            wait_cnt_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            mem_addr_q   <= mem_addr_d;
            fetch_ack_q  <= fetch_ack_d;
            dbg_ack_q    <= dbg_ack_d;
            fetch_data_q <= fetch_data_d;
            dbg_data_q   <= dbg_data_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign MemAddress = mem_addr_q;
    assign FetchAck   = fetch_ack_q;
    assign FetchData  = fetch_data_q;
    assign DbgAck     = dbg_ack_q;
    assign DbgData    = dbg_data_q;
    assign Busy       = (state_q == StIssue);

endmodule
